// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver: FSM state encoding and the
// 16x oversampling constants (ticks per bit, mid-bit sample point).
// No ports; imported by uart_rx.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;  // baudticks per bit
  localparam int unsigned MID_TICK   = 7;   // tick index of the start-bit mid-point

  localparam logic [3:0] T_MID  = 4'(MID_TICK);
  localparam logic [3:0] T_LAST = 4'(OVERSAMPLE - 1);

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial input. Both flops reset
// to the line's idle level so a reset never looks like a start edge.
// Ports:
//   clk      - system clock
//   resetn   - asynchronous active-low reset
//   async_i  - asynchronous input
//   sync_o   - synchronized output (two-cycle latency)
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 16x-oversampled UART receiver with a one-entry holding register and
// ready/valid hand-off to the consumer.
// Parameters:
//   DBIT     - data bits per frame (LSB first on the line)
//   SB_TICK  - baudticks spent in the stop bit
// Ports:
//   clk       - system clock, rising edge
//   resetn    - asynchronous active-low reset
//   baudtick  - one-cycle enable at 16x the bit rate
//   rx        - asynchronous serial line, idle high
//   rx_data   - received word, valid while rx_valid=1
//   rx_valid  - holding register full
//   rx_ready  - consumer accepts rx_data when rx_valid & rx_ready
//   frame_err - one-cycle pulse when the stop-bit sample is 0
//   overrun   - one-cycle pulse when a good frame is dropped (register full)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            baudtick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun
);

  localparam int            NW          = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [3:0]    T_STOP_LAST = 4'(SB_TICK - 1);

  logic            rx_s;
  rx_state_e       state_q;
  logic [3:0]      t_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] sh_q;
  // Set once the line has been seen high in IDLE; a start edge is only
  // accepted while armed, so a held-low line (break) cannot re-trigger.
  logic            armed_q;

  logic [DBIT-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            stop_end;
  logic            frame_ok;
  logic            frame_bad;
  logic            accept;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .async_i (rx),
    .sync_o  (rx_s)
  );

  // ---------------------------------------------------------------------------
  // Receive FSM: counters advance only on baudtick and are cleared explicitly.
  // ---------------------------------------------------------------------------
  // NOTE: the shift register is reset along with the control state so that a
  // frame abandoned by reset leaves no stale bits behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          t_q <= '0;
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= ST_START;
            armed_q <= 1'b0;
          end
        end

        ST_START: begin
          if (baudtick) begin
            if (t_q == T_MID) begin
              t_q <= '0;
              if (!rx_s) begin
                state_q <= ST_DATA;
                n_q     <= '0;
              end else begin
                state_q <= ST_IDLE;  // glitch: line back high at mid-start
              end
            end else begin
              t_q <= t_q + 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (baudtick) begin
            if (t_q == T_LAST) begin
              t_q  <= '0;
              sh_q <= {rx_s, sh_q[DBIT-1:1]};
              if (n_q == N_LAST) begin
                state_q <= ST_STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              t_q <= t_q + 4'd1;
            end
          end
        end

        ST_STOP: begin
          if (baudtick) begin
            if (t_q == T_STOP_LAST) begin
              t_q     <= '0;
              state_q <= ST_IDLE;
            end else begin
              t_q <= t_q + 4'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Last stop-bit tick: the frame resolves to done or error here.
  assign stop_end  = (state_q == ST_STOP) && baudtick && (t_q == T_STOP_LAST);
  assign frame_ok  = stop_end &&  rx_s;
  assign frame_bad = stop_end && !rx_s;
  assign accept    = rx_valid_q && rx_ready;

  // ---------------------------------------------------------------------------
  // Holding register and status pulses.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_bad;
    overrun_d   = 1'b0;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    if (frame_ok) begin
      // A same-cycle accept frees the slot for the new word.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = sh_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;  // keep the unread word, drop the new one
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. A frame-level model predicts the sequence of
// deliveries, frame errors and overruns; a compare process matches every
// observed output event against it and checks hold stability each cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int EV_ERR = 256;
  localparam int EV_OVR = 512;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       baudtick = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_vec = 0;
  int n_miss = 0;

  int exp_q[$];
  bit mdl_full = 1'b0;
  int valid_cycles = 0;
  int err_seen = 0;
  int ovr_seen = 0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .baudtick  (baudtick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;  // 50 MHz

  // Baud generator: one-cycle tick every 28 clocks.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt == 27) ? 0 : cnt + 1;
      baudtick = (cnt == 27);
    end
  end

  initial begin
    #(1_800_000);
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input int obs, input string what);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL unexpected_%s: got 0x%0h, expected no event", what, obs);
    end else begin
      int e;
      e = exp_q.pop_front();
      if (obs != e) begin
        n_miss++;
        $display("FAIL event_%s: got 0x%0h, expected 0x%0h", what, obs, e);
      end
    end
  endtask

  // Frame-level model of the holding register.
  task automatic predict(input logic [7:0] d, input bit stop_ok,
                         input bit ready_at_done, input bit ready_after);
    if (!stop_ok) begin
      exp_q.push_back(EV_ERR);
    end else if (!mdl_full || ready_at_done) begin
      exp_q.push_back(int'(d));
      mdl_full = !ready_after;
    end else begin
      exp_q.push_back(EV_OVR);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!baudtick);
    end
  endtask

  // Start edge aligned right after a tick; the receiver completes the frame
  // on tick 152 (8 start + 8*16 data + 16 stop). pulse raises rx_ready for
  // exactly that cycle.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pulse);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    predict(d, stop, rx_ready | pulse, rx_ready);
    wait_ticks(1);
    @(negedge clk); rx = fr[0];
    for (int i = 1; i < 10; i++) begin
      wait_ticks(16);
      @(negedge clk); rx = fr[i];
    end
    wait_ticks(7);
    @(negedge clk); if (pulse) rx_ready = 1'b1;
    wait_ticks(1);
    @(negedge clk); if (pulse) rx_ready = 1'b0;
    wait_ticks(8);
    @(negedge clk); rx = 1'b1;
  endtask

  task automatic set_ready(input bit v);
    @(negedge clk);
    rx_ready = v;
    if (v) mdl_full = 1'b0;
  endtask

  // Compare process: one sample per cycle, 1 time unit after the edge.
  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        pv = 1'b0;
        pd = '0;
      end else begin
        if (frame_err === 1'b1) begin err_seen++; score(EV_ERR, "frame_err"); end
        if (overrun === 1'b1)   begin ovr_seen++; score(EV_OVR, "overrun");   end
        if (rx_valid === 1'b1) valid_cycles++;
        if (rx_valid === 1'b1 && (!pv || rx_ready)) score(int'(rx_data), "delivery");
        if (pv && !rx_ready) begin
          check("hold_valid", rx_valid, 1);
          check("hold_data", rx_data, pd);
        end
        pv = rx_valid;
        pd = rx_data;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame, consumer always ready
    set_ready(1'b1);
    valid_cycles = 0;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid_after", rx_valid, 0);
    check("a5_pending", exp_q.size(), 0);

    // Short start-bit glitch, then a normal frame
    wait_ticks(1);
    @(negedge clk); rx = 1'b0;
    wait_ticks(4);
    @(negedge clk); rx = 1'b1;
    wait_ticks(20);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr_cnt", err_seen, 0);
    send_frame(8'h96, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("post_glitch_data", rx_data, 8'h96);

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("ferr_cnt", err_seen, 1);
    check("ferr_valid", rx_valid, 0);
    check("ferr_data_kept", rx_data, 8'h96);
    check("ferr_pending", exp_q.size(), 0);

    // Overrun with consumer stalled, then drain
    set_ready(1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("ovr_cnt", ovr_seen, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    set_ready(1'b1);
    repeat (2) @(negedge clk);
    check("drain_valid", rx_valid, 0);
    check("drain_data", rx_data, 8'h11);

    // Accept in the exact completion cycle of the next frame
    set_ready(1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("same_cycle_valid", rx_valid, 1);
    check("same_cycle_data", rx_data, 8'h55);
    check("same_cycle_ovr_cnt", ovr_seen, 1);
    check("same_cycle_pending", exp_q.size(), 0);

    // Reset during bit 3 of 0xFF, then a clean frame
    wait_ticks(1);
    @(negedge clk); rx = 1'b0;
    wait_ticks(16);
    @(negedge clk); rx = 1'b1;
    wait_ticks(56);
    @(negedge clk); resetn = 1'b0;
    mdl_full = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 8'h00);
    resetn = 1'b1;
    wait_ticks(100);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("post_rst_data", rx_data, 8'h81);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_ferr_cnt", err_seen, 1);

    // Break: one frame error, no re-trigger while the line stays low
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    predict(8'h00, 1'b0, 1'b1, 1'b1);
    wait_ticks(1);
    @(negedge clk); rx = 1'b0;
    wait_ticks(400);
    @(negedge clk); rx = 1'b1;
    wait_ticks(20);
    check("break_ferr_cnt", err_seen, 2);
    check("break_pending", exp_q.size(), 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("post_break_data", rx_data, 8'h5A);
    check("post_break_valid", rx_valid, 0);

    check("final_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_uart_rx
